pll_lock_supervisor: RTL and testbench

- Consumer side of the PLL wrapper interface: drives the PLL `rst` input, watches the asynchronous `locked` output, and produces a clean, qualified reset for the logic clocked by the PLL outputs.
- Runs on the 74.25 MHz reference clock, so it stays alive while the PLL is unlocked.
- Re-issues a PLL reset on lock timeout or loss of lock.
- Reports lock-loss statistics to the bridge/status logic.

---
 rtl/pll_lock_supervisor.sv | 156 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier on the reference clock.
// With PLL_LOCK_RETRY_LIMIT_EN defined, repeated lock timeouts end in a sticky FAIL state.
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 74250,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 8,
  parameter int CNT_W              = 17
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic [7:0] lock_lost_count,
  output logic [7:0] retry_count,
  output logic [2:0] state_o,
  output logic       pll_fail
);

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LAST  = 8'(MAX_RETRIES - 1);

`ifdef PLL_LOCK_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT_EN = 1'b1;
`else
  localparam bit RETRY_LIMIT_EN = 1'b0;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_d, lost_d;
  logic             pll_rst_d, sys_reset_n_d, fail_d;
  logic             retry_limit_hit;
  logic             locked_p0, locked_s;

  // Stage p0/p1: two-flop synchronizer for the asynchronous lock pin
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      locked_p0 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_p0 <= pll_locked;
      locked_s  <= locked_p0;
    end
  end

  assign retry_limit_hit = RETRY_LIMIT_EN && (retry_count == RETRY_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_count;
    lost_d  = lock_lost_count;
    case (state_q)
      PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over the retry.
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = retry_limit_hit ? FAIL : PLLRST;
          cnt_d   = '0;
          retry_d = sat_inc(retry_count);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PLLRST;
          cnt_d   = '0;
          lost_d  = sat_inc(lock_lost_count);
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = PLLRST;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they register in step with state_o.
    pll_rst_d     = (state_d == PLLRST) || (state_d == FAIL);
    sys_reset_n_d = (state_d == RUN);
    fail_d        = (state_d == FAIL);
  end

  // Stage p2: FSM state, counter and registered outputs
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= PLLRST;
      cnt_q           <= '0;
      retry_count     <= 8'd0;
      lock_lost_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_count     <= retry_d;
      lock_lost_count <= lost_d;
      pll_rst         <= pll_rst_d;
      sys_reset_n     <= sys_reset_n_d;
    end
  end

  assign state_o = state_q;

`ifdef PLL_LOCK_RETRY_LIMIT_EN
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) pll_fail <= 1'b0;
    else          pll_fail <= fail_d;
  end
`else
  logic unused_fail;
  assign unused_fail = fail_d;
  assign pll_fail    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: directed lock/unlock scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam logic [2:0] S_PLLRST = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic       clk_74a = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_reset_n, pll_fail;
  logic [7:0] lock_lost_count, retry_count;
  logic [2:0] state_o;

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] st;
    logic       prst;
    logic       srn;
    logic [7:0] lost;
    logic [7:0] retry;
    logic       fail;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   t0 = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(3),
    .CNT_W(17)
  ) dut (
    .clk_74a(clk_74a),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .lock_lost_count(lock_lost_count),
    .retry_count(retry_count),
    .state_o(state_o),
    .pll_fail(pll_fail)
  );

  always #5 clk_74a = ~clk_74a;
  always @(posedge clk_74a) edge_cnt <= edge_cnt + 1;

  task automatic expect_at(input string name, input int k, input logic [2:0] st, input logic prst,
                           input logic srn, input logic [7:0] lost, input logic [7:0] retry,
                           input logic fail);
    exp_t e;
    e.name = name; e.cyc = t0 + k; e.st = st; e.prst = prst; e.srn = srn;
    e.lost = lost; e.retry = retry; e.fail = fail;
    q.push_back(e);
  endtask

  // Advance to 2 time units after the posedge that starts phase cycle k.
  task automatic goto(input int k);
    while (edge_cnt < t0 + k) begin
      @(posedge clk_74a);
      #2;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    t0 = edge_cnt;
    expect_at("rst_now", 0, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("rst_hold", 2, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    goto(3);
    reset_n = 1'b1;
    t0 = edge_cnt;
  endtask

  always @(negedge clk_74a) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < edge_cnt) begin
        errors++;
        $display("FAIL %s: sampled at edge %0d, required at edge %0d", e.name, edge_cnt, e.cyc);
      end else if (state_o !== e.st || pll_rst !== e.prst || sys_reset_n !== e.srn ||
                   lock_lost_count !== e.lost || retry_count !== e.retry || pll_fail !== e.fail) begin
        errors++;
        $display("FAIL %s: got st=%0d pll_rst=%b srn=%b lost=%0d retry=%0d fail=%b, expected st=%0d pll_rst=%b srn=%b lost=%0d retry=%0d fail=%b",
                 e.name, state_o, pll_rst, sys_reset_n, lock_lost_count, retry_count, pll_fail,
                 e.st, e.prst, e.srn, e.lost, e.retry, e.fail);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk_74a);
    #2;

    // Normal bring-up
    apply_reset();
    expect_at("up_c0",  0,  S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("up_c3",  3,  S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("up_c4",  4,  S_WAIT,   1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("up_c12", 12, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("up_c13", 13, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("up_c20", 20, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("up_c21", 21, S_RUN,    1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    goto(10); pll_locked = 1'b1;
    goto(22);

    // Glitch while in STABLE
    pll_locked = 1'b0;
    apply_reset();
    expect_at("gl_c13", 13, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("gl_c17", 17, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("gl_c18", 18, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("gl_c19", 19, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("gl_c26", 26, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("gl_c27", 27, S_RUN,    1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    // Loss of lock in RUN, then re-lock
    expect_at("ll_c32", 32, S_RUN,    1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    expect_at("ll_c33", 33, S_PLLRST, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0);
    expect_at("ll_c36", 36, S_PLLRST, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0);
    expect_at("ll_c37", 37, S_WAIT,   1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    expect_at("ll_c51", 51, S_RUN,    1'b0, 1'b1, 8'd1, 8'd0, 1'b0);
    // Second loss, then async reset while STABLE
    expect_at("ar_c58", 58, S_PLLRST, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0);
    expect_at("ar_c63", 63, S_STABLE, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0);
    expect_at("ar_c64", 64, S_STABLE, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0);
    goto(10); pll_locked = 1'b1;
    goto(15); pll_locked = 1'b0;
    goto(16); pll_locked = 1'b1;
    goto(30); pll_locked = 1'b0;
    goto(40); pll_locked = 1'b1;
    goto(55); pll_locked = 1'b0;
    goto(60); pll_locked = 1'b1;
    goto(65);
    apply_reset();
    expect_at("ar_c4",  4,  S_WAIT,   1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("ar_c5",  5,  S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("ar_c12", 12, S_STABLE, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("ar_c13", 13, S_RUN,    1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    goto(14);

    // Lock timeout with pll_locked held low
    pll_locked = 1'b0;
    apply_reset();
    expect_at("to_c4",  4,  S_WAIT,   1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("to_c23", 23, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    expect_at("to_c24", 24, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0);
    expect_at("to_c27", 27, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0);
    expect_at("to_c28", 28, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    expect_at("to_c48", 48, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0);
    expect_at("to_c71", 71, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd2, 1'b0);
`ifdef PLL_LOCK_RETRY_LIMIT_EN
    expect_at("lim_c72",  72,  S_FAIL, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1);
    expect_at("lim_c200", 200, S_FAIL, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1);
    goto(201);
`else
    expect_at("to_c72",   72,   S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd3,   1'b0);
    expect_at("to_c6119", 6119, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd254, 1'b0);
    expect_at("to_c6120", 6120, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd255, 1'b0);
    expect_at("to_c6144", 6144, S_PLLRST, 1'b1, 1'b0, 8'd0, 8'd255, 1'b0);
    expect_at("to_c6148", 6148, S_WAIT,   1'b0, 1'b0, 8'd0, 8'd255, 1'b0);
    goto(6150);
`endif

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk_74a);
    if (q.size() > 0) begin
      errors += q.size();
      $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
